icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 Param LINE_WORDS, default 4, words per cache line (power of two).
REQ-002 Param NUM_LINES, default 16, number of direct-mapped lines (power of two).
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port icache_req_addr  in  12  instruction word address (byte addr [13:2]).
REQ-006 Port icache_req_valid  in  1  fetch request present.
REQ-007 Port icache_req_rw  in  1  0=read; 1 treated as read (no writes supported).
REQ-008 Port icache_data_read  out  32  instruction word for icache_req_addr.
REQ-009 Port icache_ready  out  1  icache_data_read valid this cycle.
REQ-010 Port icache_hit  out  1  1=served from array, 0=served by refill completion.
REQ-011 Port fence_i  in  1  invalidate all lines.
REQ-012 Port mem_req_valid / mem_req_addr  out  1 / 12  backing-memory word read request.
REQ-013 Port mem_req_ready  in  1  memory accepts request this cycle.
REQ-014 Port mem_rsp_valid / mem_rsp_data  in  1 / 32  read response, in request order.
REQ-015 Port perf_hit_cnt / perf_miss_cnt  out  32 / 32  performance counters.

Function
REQ-016 Address split: offset=log2(LINE_WORDS) LSBs, index=next log2(NUM_LINES) bits, tag=remaining upper bits (defaults 2/4/6).
REQ-017 FSM states IDLE, REFILL, DONE; reset state IDLE.
REQ-018 IDLE, req_valid=1, valid[index]=1 and tag match: icache_ready=1, icache_hit=1, data from array same cycle (combinational lookup, zero latency).
REQ-019 IDLE, req_valid=1, miss: ready=0, hit=0; latch address into miss_addr; next state REFILL.
REQ-020 IDLE, req_valid=0: ready=0, hit=0, no state change.
REQ-021 REFILL: issue LINE_WORDS requests at line base + 0..LINE_WORDS-1 in order; mem_req_valid held with stable mem_req_addr until mem_req_ready; at most one outstanding request.
REQ-022 REFILL: each mem_rsp_valid writes the word into line buffer; after last response write tag, set valid, go DONE.
REQ-023 REFILL: icache_ready=0 regardless of req_addr.
REQ-024 DONE (one cycle): if req_addr==miss_addr then ready=1, hit=0, data=refilled word; otherwise ready=0; always return to IDLE.
REQ-025 fence_i=1 clears all valid bits next edge; in IDLE that cycle, lookup result forced to miss.
REQ-026 fence_i during REFILL: refill completes and DONE returns data, but line is left invalid.
REQ-027 mem_rsp_valid outside REFILL is ignored.
REQ-028 icache_data_read=32'h0 whenever ready=0.

Reset
REQ-029 rst asserted: state IDLE, all valid bits 0, mem_req_valid=0, ready=0, hit=0, counters 0, word counters 0.
REQ-030 rst mid-REFILL abandons refill; later responses ignored; data/tag arrays need not reset.

Configuration
REQ-031 ICACHE_PERF_EN defined: perf_hit_cnt increments per REQ-018 cycle, perf_miss_cnt per REQ-019 transition, both wrap at 2^32.
REQ-032 ICACHE_PERF_EN undefined: counter logic absent, both perf ports constant 0.

Structure
REQ-033 Package icache_pkg holds default LINE_WORDS, NUM_LINES, derived offset/index/tag widths and FSM state enum.
REQ-034 Data storage in sub-module icache_data_ram (async read, sync word write); tag/valid arrays in icache.

Verification
REQ-035 Reset, req 0x010 cold -> ready=0; mem requests 0x010,0x011,0x012,0x013; after 4th rsp, DONE ready=1 hit=0 data=rsp word 0.
REQ-036 Following cycle req 0x012 -> ready=1 hit=1 same cycle, data=3rd refilled word; perf_hit_cnt=1 with ICACHE_PERF_EN.
REQ-037 req 0x410 (same index, tag differs) after REQ-035 -> miss, refill of 0x410..0x413, old line replaced; req 0x010 misses again.
REQ-038 mem_req_ready held 0 for 5 cycles -> mem_req_valid/addr stable throughout, no duplicate request.
REQ-039 fence_i pulse then req 0x011 -> miss; fence_i mid-refill -> DONE data correct, next req same address misses.
REQ-040 rst asserted after 2 responses -> IDLE, mem_req_valid=0 immediately; stray responses ignored; next req misses cleanly.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// icache_pkg: default geometry, derived address-field widths and FSM state encoding for icache.
package icache_pkg;
  localparam int ICACHE_ADDR_W     = 12;
  localparam int ICACHE_DATA_W     = 32;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 16;
  localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_IDX_W      = $clog2(ICACHE_NUM_LINES);
  localparam int ICACHE_TAG_W      = ICACHE_ADDR_W - ICACHE_OFF_W - ICACHE_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } icache_state_e;
endpackage
`default_nettype wire

// File: rtl/icache_data_ram.sv
`default_nettype none
// icache_data_ram: word-addressed instruction data store, asynchronous read, synchronous word write.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int DEPTH = ICACHE_NUM_LINES * ICACHE_LINE_WORDS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [ICACHE_DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic [ICACHE_DATA_W-1:0] rdata
);
  logic [ICACHE_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// icache: direct-mapped instruction cache, zero-latency hit, one-request-at-a-time line refill.
// Define ICACHE_PERF_EN to build the hit/miss performance counters.
module icache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ICACHE_ADDR_W-1:0] icache_req_addr,
  input  logic                     icache_req_valid,
  input  logic                     icache_req_rw,
  output logic [ICACHE_DATA_W-1:0] icache_data_read,
  output logic                     icache_ready,
  output logic                     icache_hit,
  input  logic                     fence_i,
  output logic                     mem_req_valid,
  output logic [ICACHE_ADDR_W-1:0] mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [ICACHE_DATA_W-1:0] mem_rsp_data,
  output logic [31:0]              perf_hit_cnt,
  output logic [31:0]              perf_miss_cnt
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ICACHE_ADDR_W - OFF_W - IDX_W;
  localparam int CNT_W  = OFF_W + 1;
  localparam int RAM_AW = IDX_W + OFF_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(LINE_WORDS);

  icache_state_e             state_q, state_d;
  logic [ICACHE_ADDR_W-1:0]  miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0]          req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]          rsp_cnt_q, rsp_cnt_d;
  logic                      outstanding_q, outstanding_d;
  logic                      fence_seen_q, fence_seen_d;
  logic [NUM_LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q [NUM_LINES];

  logic [OFF_W-1:0]          req_off;
  logic [IDX_W-1:0]          req_idx, miss_idx;
  logic [TAG_W-1:0]          req_tag, miss_tag;
  logic                      lookup_cyc, lookup_hit;
  logic                      tag_we, ram_we;
  logic [ICACHE_DATA_W-1:0]  ram_rdata;
  logic                      unused_rw;

  // Writes are not supported; rw is accepted and treated as a read.
  assign unused_rw = icache_req_rw;

  assign req_off  = icache_req_addr[OFF_W-1:0];
  assign req_idx  = icache_req_addr[OFF_W +: IDX_W];
  assign req_tag  = icache_req_addr[ICACHE_ADDR_W-1 -: TAG_W];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag = miss_addr_q[ICACHE_ADDR_W-1 -: TAG_W];

  // A fence in the same cycle as a lookup must not return stale code.
  assign lookup_cyc = (state_q == IDLE) && icache_req_valid;
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !fence_i;

  assign mem_req_addr = {miss_addr_q[ICACHE_ADDR_W-1:OFF_W], req_cnt_q[OFF_W-1:0]};

  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    req_cnt_d     = req_cnt_q;
    rsp_cnt_d     = rsp_cnt_q;
    outstanding_d = outstanding_q;
    fence_seen_d  = fence_seen_q;
    valid_d       = fence_i ? '0 : valid_q;
    icache_ready  = 1'b0;
    icache_hit    = 1'b0;
    tag_we        = 1'b0;
    ram_we        = 1'b0;
    mem_req_valid = (state_q == REFILL) && !outstanding_q && (req_cnt_q != ALL_WORDS);

    unique case (state_q)
      IDLE: begin
        if (icache_req_valid) begin
          if (lookup_hit) begin
            icache_ready = 1'b1;
            icache_hit   = 1'b1;
          end else begin
            miss_addr_d   = icache_req_addr;
            req_cnt_d     = '0;
            rsp_cnt_d     = '0;
            outstanding_d = 1'b0;
            fence_seen_d  = 1'b0;
            state_d       = REFILL;
          end
        end
      end
      REFILL: begin
        if (fence_i) fence_seen_d = 1'b1;
        if (mem_req_valid && mem_req_ready) begin
          req_cnt_d     = req_cnt_q + CNT_W'(1);
          outstanding_d = 1'b1;
        end
        // Only a response to our own outstanding request is consumed.
        if (mem_rsp_valid && outstanding_q) begin
          ram_we        = 1'b1;
          rsp_cnt_d     = rsp_cnt_q + CNT_W'(1);
          outstanding_d = 1'b0;
          if (rsp_cnt_q == LAST_WORD) begin
            tag_we  = 1'b1;
            state_d = DONE;
            if (!fence_seen_q && !fence_i) valid_d[miss_idx] = 1'b1;
          end
        end
      end
      DONE: begin
        icache_ready = (icache_req_addr == miss_addr_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign icache_data_read = icache_ready ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      miss_addr_q   <= '0;
      req_cnt_q     <= '0;
      rsp_cnt_q     <= '0;
      outstanding_q <= 1'b0;
      fence_seen_q  <= 1'b0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      req_cnt_q     <= req_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      outstanding_q <= outstanding_d;
      fence_seen_q  <= fence_seen_d;
      valid_q       <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[miss_idx] <= miss_tag;
  end

  icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({miss_idx, rsp_cnt_q[OFF_W-1:0]}),
    .wdata (mem_rsp_data),
    .raddr ({req_idx, req_off}),
    .rdata (ram_rdata)
  );

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_cyc) begin
      if (lookup_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else            miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  logic unused_lookup_cyc;
  assign unused_lookup_cyc = lookup_cyc;
  assign perf_hit_cnt      = '0;
  assign perf_miss_cnt     = '0;
`endif
endmodule
`default_nettype wire
